// File: rtl/sum_split.sv
// Round-robin scatter of a sample stream over five lane accumulators (sum and sum of squares),
// with frame counting and a done pulse. Define SUM_SPLIT_SIGNED_EN for two's-complement samples.
module sum_split #(
  parameter int DATA_W    = 16,
  parameter int FRAME_LEN = 1024
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic [63:0]       sum_0,
  output logic [63:0]       sum_1,
  output logic [63:0]       sum_2,
  output logic [63:0]       sum_3,
  output logic [63:0]       sum_4,
  output logic [63:0]       sum_square_0,
  output logic [63:0]       sum_square_1,
  output logic [63:0]       sum_square_2,
  output logic [63:0]       sum_square_3,
  output logic [63:0]       sum_square_4,
  output logic [31:0]       sample_cnt,
  output logic              busy,
  output logic              done
);

  localparam int LANES = 5;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    FLUSH = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t      state_r;
  logic [63:0] sum_r [LANES];
  logic [63:0] sq_r  [LANES];
  logic [2:0]  ptr_r;
  logic [31:0] cnt_r;
  logic        in_ready_r;
  logic        busy_r;
  logic        done_r;
  logic [63:0] ext_s;
  logic [63:0] sq_s;

  function automatic logic [63:0] ext_f(input logic [DATA_W-1:0] d);
`ifdef SUM_SPLIT_SIGNED_EN
    ext_f = 64'($signed(d));
`else
    ext_f = 64'(d);
`endif
  endfunction

  // Extended sample and its square; the 64-bit product is exact since 2*DATA_W <= 64.
  always_comb begin
    ext_s = ext_f(in_data);
    sq_s  = ext_s * ext_s;
  end

  // Frame FSM, lane pointer, sample counter and lane accumulators.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r    <= IDLE;
      ptr_r      <= 3'd0;
      cnt_r      <= 32'd0;
      in_ready_r <= 1'b0;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      for (int k = 0; k < LANES; k++) begin
        sum_r[k] <= 64'd0;
        sq_r[k]  <= 64'd0;
      end
    end else begin
      case (state_r)
        IDLE: begin
          done_r <= 1'b0;
          if (start) begin
            for (int k = 0; k < LANES; k++) begin
              sum_r[k] <= 64'd0;
              sq_r[k]  <= 64'd0;
            end
            ptr_r      <= 3'd0;
            cnt_r      <= 32'd0;
            in_ready_r <= 1'b1;
            busy_r     <= 1'b1;
            state_r    <= ACCUM;
          end
        end
        ACCUM: begin
          if (in_valid && in_ready_r) begin
            for (int k = 0; k < LANES; k++) begin
              if (ptr_r == 3'(k)) begin
                sum_r[k] <= sum_r[k] + ext_s;
                sq_r[k]  <= sq_r[k] + sq_s;
              end
            end
            ptr_r <= (ptr_r == 3'd4) ? 3'd0 : ptr_r + 3'd1;
            cnt_r <= cnt_r + 32'd1;
            if (cnt_r + 32'd1 == 32'(FRAME_LEN)) begin
              in_ready_r <= 1'b0;
              state_r    <= FLUSH;
            end
          end
        end
        // One idle cycle lets the merge stage register the final lane values.
        FLUSH: begin
          done_r  <= 1'b1;
          state_r <= DONE;
        end
        DONE: begin
          done_r  <= 1'b0;
          busy_r  <= 1'b0;
          state_r <= IDLE;
        end
        default: begin
          in_ready_r <= 1'b0;
          busy_r     <= 1'b0;
          done_r     <= 1'b0;
          state_r    <= IDLE;
        end
      endcase
    end
  end

  assign in_ready     = in_ready_r;
  assign busy         = busy_r;
  assign done         = done_r;
  assign sample_cnt   = cnt_r;
  assign sum_0        = sum_r[0];
  assign sum_1        = sum_r[1];
  assign sum_2        = sum_r[2];
  assign sum_3        = sum_r[3];
  assign sum_4        = sum_r[4];
  assign sum_square_0 = sq_r[0];
  assign sum_square_1 = sq_r[1];
  assign sum_square_2 = sq_r[2];
  assign sum_square_3 = sq_r[3];
  assign sum_square_4 = sq_r[4];

endmodule

// File: tb/tb_sum_split.sv
// Self-checking bench for sum_split: a 10-sample-frame instance and a 5-sample-frame instance,
// checked against a queue-based reference model of the lane arithmetic.
module tb_sum_split;
  localparam int DW   = 16;
  localparam int FL   = 10;
  localparam int FL_B = 5;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic          in_valid = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic          a_in_ready, a_busy, a_done;
  logic [31:0]   a_cnt;
  logic [63:0]   a_sum [5];
  logic [63:0]   a_sq  [5];

  logic          b_start = 1'b0;
  logic          b_valid = 1'b0;
  logic [DW-1:0] b_data = '0;
  logic          b_in_ready, b_busy, b_done;
  logic [31:0]   b_cnt;
  logic [63:0]   b_sum [5];
  logic [63:0]   b_sq  [5];

  int            n_cmp = 0;
  int            n_bad = 0;
  int            cyc = 0;
  int            last_acc = 0;
  int            last_acc_b = 0;
  logic [DW-1:0] q_a[$];
  logic [DW-1:0] q_b[$];
  logic [DW-1:0] src [FL];

  always #5 clk = ~clk;

  sum_split #(.DATA_W(DW), .FRAME_LEN(FL)) dut_a (
    .clk(clk), .reset(reset), .start(start), .in_valid(in_valid), .in_ready(a_in_ready),
    .in_data(in_data),
    .sum_0(a_sum[0]), .sum_1(a_sum[1]), .sum_2(a_sum[2]), .sum_3(a_sum[3]), .sum_4(a_sum[4]),
    .sum_square_0(a_sq[0]), .sum_square_1(a_sq[1]), .sum_square_2(a_sq[2]),
    .sum_square_3(a_sq[3]), .sum_square_4(a_sq[4]),
    .sample_cnt(a_cnt), .busy(a_busy), .done(a_done)
  );

  sum_split #(.DATA_W(DW), .FRAME_LEN(FL_B)) dut_b (
    .clk(clk), .reset(reset), .start(b_start), .in_valid(b_valid), .in_ready(b_in_ready),
    .in_data(b_data),
    .sum_0(b_sum[0]), .sum_1(b_sum[1]), .sum_2(b_sum[2]), .sum_3(b_sum[3]), .sum_4(b_sum[4]),
    .sum_square_0(b_sq[0]), .sum_square_1(b_sq[1]), .sum_square_2(b_sq[2]),
    .sum_square_3(b_sq[3]), .sum_square_4(b_sq[4]),
    .sample_cnt(b_cnt), .busy(b_busy), .done(b_done)
  );

  function automatic logic [63:0] ext(input logic [DW-1:0] d);
`ifdef SUM_SPLIT_SIGNED_EN
    return 64'($signed(d));
`else
    return 64'(d);
`endif
  endfunction

  // Reference: lane k holds samples k, k+5, k+10, ... of the accepted sequence.
  function automatic logic [63:0] lane_val(input bit use_b, input int k, input bit squares);
    logic [63:0] acc;
    logic [63:0] v;
    int n;
    acc = 64'd0;
    n = use_b ? q_b.size() : q_a.size();
    for (int i = 0; i < n; i++) begin
      if (i % 5 == k) begin
        v = ext(use_b ? q_b[i] : q_a[i]);
        acc = acc + (squares ? v * v : v);
      end
    end
    return acc;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_lanes(input bit use_b, input string tag);
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("%s_sum%0d", tag, k), use_b ? b_sum[k] : a_sum[k], lane_val(use_b, k, 1'b0));
      chk($sformatf("%s_sq%0d", tag, k), use_b ? b_sq[k] : a_sq[k], lane_val(use_b, k, 1'b1));
    end
  endtask

  // One clock: record handshakes presented this cycle, then advance past the edge.
  task automatic tick();
    if (in_valid && a_in_ready) begin
      q_a.push_back(in_data);
      last_acc = cyc;
    end
    if (b_valid && b_in_ready) begin
      q_b.push_back(b_data);
      last_acc_b = cyc;
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Start a frame on dut_a, feed src with random gaps, optionally pulse start mid-frame.
  task automatic run_frame(input int gap_pct, input int start_at);
    int guard;
    bit pulsed;
    pulsed = 1'b0;
    q_a.delete();
    start = 1'b1;
    in_valid = 1'b0;
    tick();
    start = 1'b0;
    chk("start_busy", 64'(a_busy), 64'd1);
    chk("start_ready", 64'(a_in_ready), 64'd1);
    chk("start_cnt", 64'(a_cnt), 64'd0);
    check_lanes(1'b0, "cleared");
    guard = 0;
    while (q_a.size() < FL && guard < 400) begin
      in_valid = ($urandom_range(99) >= gap_pct);
      in_data = src[q_a.size()];
      if (q_a.size() == start_at && !pulsed) begin
        start = 1'b1;
        pulsed = 1'b1;
      end
      tick();
      start = 1'b0;
      guard++;
      chk("cnt_track", 64'(a_cnt), 64'(q_a.size()));
      if (q_a.size() < FL) chk("early_done", 64'(a_done), 64'd0);
    end
    in_valid = 1'b0;
    guard = 0;
    while (!a_done && guard < 10) begin
      tick();
      guard++;
    end
    chk("done_seen", 64'(a_done), 64'd1);
    // done is high in the second cycle after the cycle that presented the last sample
    chk("done_latency", 64'(cyc - last_acc), 64'd2);
    chk("final_cnt", 64'(a_cnt), 64'(FL));
    check_lanes(1'b0, "frame");
    tick();
    chk("done_pulse", 64'(a_done), 64'd0);
    chk("busy_end", 64'(a_busy), 64'd0);
    chk("ready_end", 64'(a_in_ready), 64'd0);
  endtask

  initial begin
    logic [63:0] exp_sum [5];
    logic [63:0] exp_sq  [5];
    logic [63:0] tot_s;
    logic [63:0] tot_q;
    int guard;
    exp_sum = '{64'd7, 64'd9, 64'd11, 64'd13, 64'd15};
    exp_sq  = '{64'd37, 64'd53, 64'd73, 64'd97, 64'd125};

    // Reset state
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    check_lanes(1'b0, "rst");
    chk("rst_cnt", 64'(a_cnt), 64'd0);
    chk("rst_ready", 64'(a_in_ready), 64'd0);
    chk("rst_busy", 64'(a_busy), 64'd0);
    chk("rst_done", 64'(a_done), 64'd0);

    // Test 1: samples 1..10 back-to-back
    for (int i = 0; i < FL; i++) src[i] = DW'(i + 1);
    run_frame(0, -1);
    tot_s = 64'd0;
    tot_q = 64'd0;
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("t1_sum%0d", k), a_sum[k], exp_sum[k]);
      chk($sformatf("t1_sq%0d", k), a_sq[k], exp_sq[k]);
      tot_s = tot_s + a_sum[k];
      tot_q = tot_q + a_sq[k];
    end
    chk("t1_total_sum", tot_s, 64'd55);
    chk("t1_total_sq", tot_q, 64'd385);

    // Test 6: back-to-back frame with random data starts from cleared lanes
    for (int i = 0; i < FL; i++) src[i] = DW'($urandom);
    run_frame(0, -1);

    // Test 2: 1..10 with random valid gaps
    for (int i = 0; i < FL; i++) src[i] = DW'(i + 1);
    run_frame(35, -1);
    for (int k = 0; k < 5; k++) chk($sformatf("t2_sum%0d", k), a_sum[k], exp_sum[k]);

    // Test 3: start pulsed after 4 samples is ignored
    run_frame(0, 4);
    for (int k = 0; k < 5; k++) chk($sformatf("t3_sq%0d", k), a_sq[k], exp_sq[k]);

    // Test 3b: start with in_valid in IDLE, the sample is not taken
    q_a.delete();
    start = 1'b1;
    in_valid = 1'b1;
    in_data = 16'd77;
    tick();
    start = 1'b0;
    chk("sv_cnt", 64'(a_cnt), 64'd0);
    chk("sv_sum0", a_sum[0], 64'd0);
    chk("sv_busy", 64'(a_busy), 64'd1);

    // Test 4: reset after 3 accepts
    guard = 0;
    while (q_a.size() < 3 && guard < 20) begin
      in_data = DW'($urandom);
      tick();
      guard++;
    end
    in_valid = 1'b0;
    chk("t4_pre_cnt", 64'(a_cnt), 64'd3);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    q_a.delete();
    check_lanes(1'b0, "t4");
    chk("t4_cnt", 64'(a_cnt), 64'd0);
    chk("t4_ready", 64'(a_in_ready), 64'd0);
    chk("t4_busy", 64'(a_busy), 64'd0);
    for (int i = 0; i < 12; i++) begin
      tick();
      chk("t4_no_done", 64'(a_done), 64'd0);
    end

    // Test 5: FRAME_LEN=5, all-ones samples
    q_b.delete();
    b_start = 1'b1;
    tick();
    b_start = 1'b0;
    b_valid = 1'b1;
    b_data = 16'hFFFF;
    guard = 0;
    while (q_b.size() < FL_B && guard < 20) begin
      tick();
      guard++;
    end
    b_valid = 1'b0;
    chk("t5_cnt", 64'(b_cnt), 64'(FL_B));
    guard = 0;
    while (!b_done && guard < 10) begin
      tick();
      guard++;
    end
    chk("t5_done", 64'(b_done), 64'd1);
    chk("t5_latency", 64'(cyc - last_acc_b), 64'd2);
    check_lanes(1'b1, "t5");
    for (int k = 0; k < 5; k++) begin
`ifdef SUM_SPLIT_SIGNED_EN
      chk($sformatf("t5c_sum%0d", k), b_sum[k], 64'hFFFF_FFFF_FFFF_FFFF);
      chk($sformatf("t5c_sq%0d", k), b_sq[k], 64'd1);
`else
      chk($sformatf("t5c_sum%0d", k), b_sum[k], 64'd65535);
      chk($sformatf("t5c_sq%0d", k), b_sq[k], 64'd4294836225);
`endif
    end
    tick();
    chk("t5_done_pulse", 64'(b_done), 64'd0);
    chk("t5_hold_sum0", b_sum[0], lane_val(1'b1, 0, 1'b0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
